// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the discrete-log engine and its helpers.
package gf_pkg;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x^2 + 1 (0x11D).
  localparam logic [7:0] GfPolyDefault = 8'h1D;

  // Order of the multiplicative group of GF(2^8).
  localparam int unsigned GfOrder = 255;

  // Last exponent worth trying; the search stops here without a match.
  localparam logic [7:0] KMax = 8'(GfOrder - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^8) multiplier: carry-less product of a and b reduced
// modulo {1, POLY}. Shift-and-add form, one partial product per bit of b.
module gf_mult
  import gf_pkg::*;
#(
  parameter logic [7:0] POLY = GfPolyDefault
) (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] acc;
  logic [7:0] shifted;

  // Accumulate a*x^i for each set bit of b, reducing a after every doubling.
  always_comb begin
    acc     = 8'h00;
    shifted = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        acc = acc ^ shifted;
      end
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? POLY : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf_discrete_log.sv
// Sequential GF(2^8) discrete logarithm: walks g^0, g^1, ... g^254 one power
// per cycle and reports the first exponent k with g^k == y, or not_found.
module gf_discrete_log
  import gf_pkg::*;
#(
  parameter logic [7:0] POLY = GfPolyDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] element_i,
  input  logic [7:0] generator_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       not_found_o,
  output logic [7:0] log_out_o
);

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [7:0] g_q, g_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] k_q, k_d;
  logic [7:0] log_q, log_d;
  logic       nf_q, nf_d;

  logic [7:0] prod;
  logic       hit;
  logic       at_last;

  // acc * g gives the next power in the same cycle.
  gf_mult #(
    .POLY (POLY)
  ) u_gf_mult (
    .a_i (acc_q),
    .b_i (g_q),
    .p_o (prod)
  );

  assign hit     = (acc_q == y_q);
  assign at_last = (k_q == KMax);

  // State register; reset is asynchronous so it can abort a search mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in idle; a zero target has no log.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = (element_i == 8'h00) ? StDone : StSearch;
        end
      end
      StSearch: begin
        if (hit || at_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: status comes straight from the state.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      StSearch: busy_o = 1'b1;
      StDone:   done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Datapath registers: operands, running power, exponent and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 8'h00;
      g_q   <= 8'h00;
      acc_q <= 8'h01;
      k_q   <= 8'h00;
      log_q <= 8'h00;
      nf_q  <= 1'b0;
    end else begin
      y_q   <= y_d;
      g_q   <= g_d;
      acc_q <= acc_d;
      k_q   <= k_d;
      log_q <= log_d;
      nf_q  <= nf_d;
    end
  end

  // Datapath next-state: the bound check happens before k increments, so k
  // stops at 254 and never wraps.
  always_comb begin
    y_d   = y_q;
    g_d   = g_q;
    acc_d = acc_q;
    k_d   = k_q;
    log_d = log_q;
    nf_d  = nf_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (element_i != 8'h00) begin
            y_d   = element_i;
            g_d   = generator_i;
            acc_d = 8'h01;
            k_d   = 8'h00;
          end else begin
            log_d = 8'h00;
            nf_d  = 1'b1;
          end
        end
      end
      StSearch: begin
        if (hit) begin
          log_d = k_q;
          nf_d  = 1'b0;
        end else if (!at_last) begin
          acc_d = prod;
          k_d   = k_q + 8'd1;
        end else begin
          log_d = 8'h00;
          nf_d  = 1'b1;
        end
      end
      default: begin
        y_d = y_q;
      end
    endcase
  end

  assign log_out_o   = log_q;
  assign not_found_o = nf_q;

endmodule

// File: doc/gf_discrete_log.md
GF_DISCRETE_LOG -- requirements
Module: gf_discrete_log

Interface
REQ-001 Parameter POLY, default 8'h1D; low 8 bits of the field polynomial x^8+x^4+x^3+x^2+1 (0x11D) that defines GF(2^8).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request a log computation; sampled only in IDLE.
REQ-005 element  input  8  target value y; captured when start is accepted.
REQ-006 generator  input  8  base g; captured when start is accepted.
REQ-007 busy  output  1  high while in SEARCH.
REQ-008 done  output  1  one-cycle pulse; result and status are valid in that cycle.
REQ-009 not_found  output  1  set with done when no k in 0..254 satisfies g^k = y.
REQ-010 log_out  output  8  smallest k with g^k = y; 0 when not_found.

Function
REQ-011 The block SHALL compute the discrete log, the inverse of GF(2^8) exponentiation: the smallest k in 0..254 such that g^k = y.
REQ-012 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-013 IDLE with start=1 and element!=0: capture y and g, set acc=8'h01 and k=0, then go to SEARCH.
REQ-014 IDLE with start=1 and element=0: go directly to DONE with not_found=1 and log_out=0.
REQ-015 SEARCH, each cycle with acc==y: log_out<=k, not_found<=0, go to DONE.
REQ-016 SEARCH, each cycle with acc!=y and k<254: acc<=gf_mult(acc,g), k<=k+1.
REQ-017 SEARCH, each cycle with acc!=y and k==254: not_found<=1, log_out<=0, go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 log_out and not_found SHALL hold their values until the next accepted start.
REQ-020 Latency: done SHALL be high in cycle k+2, counting the start-sampling edge as edge 0.
REQ-021 element=0: done SHALL be high in cycle 1.
REQ-022 No match: done SHALL be high in cycle 256.
REQ-023 start SHALL be ignored in SEARCH and DONE; element and generator changes after capture SHALL have no effect.
REQ-024 generator=0 or 1, or non-primitive g: the search SHALL terminate through REQ-017 unless a match occurs first (g=0 and y=1 gives k=0).
REQ-025 k SHALL be an 8-bit counter that never wraps; the bound check precedes increment.
REQ-026 The GF multiply SHALL be combinational and single-cycle: carry-less product reduced modulo {1,POLY}.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, independent of clk, including mid-SEARCH.
REQ-028 Reset values: busy=0, done=0, not_found=0, log_out=0, acc=1, k=0.
REQ-029 A start sampled in the first clk edge after rst deasserts SHALL be accepted.

Structure
REQ-030 Shared package gf_pkg SHALL hold the POLY default, GF_ORDER=255, and the state enum {IDLE,SEARCH,DONE}.
REQ-031 The design SHALL use one combinational sub-module, gf_mult (a, b -> a*b mod POLY), instantiated once; gf_mult is reusable by the exponentiation engine.
REQ-032 No other sub-modules; target size 120-400 lines of RTL.

Verification
REQ-033 g=8'h02, y=8'h01 -> done in cycle 2, log_out=0, not_found=0.
REQ-034 g=8'h02, y=8'h1D -> done in cycle 10, log_out=8; y=8'h8E -> done in cycle 256, log_out=254.
REQ-035 y=8'h00 -> done in cycle 1, not_found=1, log_out=0; g=8'h01, y=8'h02 -> done in cycle 256, not_found=1.
REQ-036 Exhaustive check: for every y!=0 with g=2, exponentiate log_out using a reference model -> result equals y; start pulses during SEARCH have no effect.
REQ-037 rst asserted at SEARCH k=100 -> busy=0 at once; outputs match REQ-028; the next start gives a correct result.
